mem_stage: RTL and testbench

- Pipeline MEM stage of the 5-stage MIPS core, directly upstream of writeback.
- Consumes the EX/MEM latch contents and runs load/store handshakes with a variable-latency data memory.
- Formats load data with byte/half extraction and sign/zero extension.
- Registers the MEM/WB bundle that writeback uses to select the ALU or DMEM result and rt/rd, and stalls upstream while a memory access is in flight.

---
 rtl/mem_stage.sv | 191 +++++++++++++++++++
 tb/tb_mem_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MIPS MEM stage: issues loads/stores to a variable-latency data memory and registers the MEM/WB bundle.
// Optional macro MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of truncating the address.
module mem_stage #(
  parameter int DM_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_o,
  input  logic [31:0] ex_b,
  input  logic [31:0] ex_insn,
  input  logic        ex_dmwe,
  input  logic        ex_rwe,
  input  logic        ex_rdst,
  input  logic        ex_rwd,
  output logic        stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_o,
  output logic [31:0] wb_d,
  output logic [31:0] wb_insn,
  output logic        wb_rwe,
  output logic        wb_rdst,
  output logic        wb_rwd,
  output logic        dm_err,
  output logic        misalign
);

  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t      state, state_next;
  logic [31:0] lat_o, lat_insn;
  logic        lat_rwe, lat_rdst, lat_rwd;
  logic [31:0] wait_cnt;

  function automatic size_t op_size(input logic [5:0] op);
    case (op)
      6'h20, 6'h24, 6'h28: op_size = SZ_BYTE;
      6'h21, 6'h25, 6'h29: op_size = SZ_HALF;
      default:             op_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic op_signed(input logic [5:0] op);
    op_signed = (op == 6'h20) || (op == 6'h21);
  endfunction

  logic        mem_op, trap, accept_mem, ack_hit, timeout_hit;
  size_t       ex_size, lat_size;
  logic [31:0] req_wdata, load_data;
  logic [3:0]  req_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ex_size = op_size(ex_insn[31:26]);
    mem_op  = ex_valid & (ex_dmwe | ex_rwd);
`ifdef MEM_MISALIGN_TRAP_EN
    trap = mem_op && (((ex_size == SZ_HALF) && ex_o[0]) ||
                      ((ex_size == SZ_WORD) && (ex_o[1:0] != 2'b00)));
`else
    trap = 1'b0;
`endif
    accept_mem  = (state == IDLE) && mem_op && !trap;
    ack_hit     = (state == WAIT) && dm_ack;
    timeout_hit = (DM_TIMEOUT != 0) && (state == WAIT) && !dm_ack &&
                  (wait_cnt == 32'(DM_TIMEOUT - 1));
    stall = accept_mem || ((state == WAIT) && !dm_ack && !timeout_hit);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_mem) state_next = WAIT;
      WAIT:    if (ack_hit || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Store lanes are big-endian: byte lane 0 is bits 31:24, half 0 is bits 31:16.
  always_comb begin
    req_wdata = ex_b;
    req_be    = 4'b1111;
    case (ex_size)
      SZ_BYTE: begin
        req_wdata = {4{ex_b[7:0]}};
        req_be    = 4'b1000 >> ex_o[1:0];
      end
      SZ_HALF: begin
        req_wdata = {2{ex_b[15:0]}};
        req_be    = ex_o[1] ? 4'b0011 : 4'b1100;
      end
      default: ;
    endcase
    if (!ex_dmwe) req_be = 4'b0000;
  end

  always_comb begin
    lat_size = op_size(lat_insn[31:26]);
    ld_byte  = 8'h00;
    case (lat_o[1:0])
      2'd0: ld_byte = dm_rdata[31:24];
      2'd1: ld_byte = dm_rdata[23:16];
      2'd2: ld_byte = dm_rdata[15:8];
      2'd3: ld_byte = dm_rdata[7:0];
      default: ;
    endcase
    ld_half = lat_o[1] ? dm_rdata[15:0] : dm_rdata[31:16];
    case (lat_size)
      SZ_BYTE: load_data = op_signed(lat_insn[31:26]) ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
      SZ_HALF: load_data = op_signed(lat_insn[31:26]) ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
      default: load_data = dm_rdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= 32'h0;
      dm_wdata <= 32'h0;
      dm_be    <= 4'h0;
      dm_err   <= 1'b0;
      misalign <= 1'b0;
      wb_valid <= 1'b0;
      wb_o     <= 32'h0;
      wb_d     <= 32'h0;
      wb_insn  <= 32'h0;
      wb_rwe   <= 1'b0;
      wb_rdst  <= 1'b0;
      wb_rwd   <= 1'b0;
      lat_o    <= 32'h0;
      lat_insn <= 32'h0;
      lat_rwe  <= 1'b0;
      lat_rdst <= 1'b0;
      lat_rwd  <= 1'b0;
      wait_cnt <= 32'h0;
    end else begin
      state    <= state_next;
      misalign <= 1'b0;
      if (state == IDLE) begin
        if (accept_mem) begin
          lat_o    <= ex_o;
          lat_insn <= ex_insn;
          lat_rwe  <= ex_rwe;
          lat_rdst <= ex_rdst;
          lat_rwd  <= ex_rwd;
          dm_req   <= 1'b1;
          dm_we    <= ex_dmwe;
          dm_addr  <= {ex_o[31:2], 2'b00};
          dm_wdata <= req_wdata;
          dm_be    <= req_be;
          wb_valid <= 1'b0;
          wait_cnt <= 32'h0;
        end else begin
          wb_valid <= ex_valid;
          wb_o     <= ex_o;
          wb_insn  <= ex_insn;
          wb_rwe   <= ex_rwe & ~trap;
          wb_rdst  <= ex_rdst;
          wb_rwd   <= ex_rwd;
          wb_d     <= 32'h0;
          misalign <= trap;
        end
      end else if (ack_hit || timeout_hit) begin
        // A timed-out access still retires, but as a no-op so no register is corrupted.
        dm_req   <= 1'b0;
        wb_valid <= 1'b1;
        wb_o     <= lat_o;
        wb_insn  <= lat_insn;
        wb_rdst  <= lat_rdst;
        wb_rwd   <= lat_rwd;
        wb_rwe   <= ack_hit & lat_rwe;
        wb_d     <= ack_hit ? load_data : 32'h0;
        if (timeout_hit) dm_err <= 1'b1;
      end else begin
        wb_valid <= 1'b0;
        wait_cnt <= wait_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, hand sequences and random ops against a reference model.
// Builds with or without MEM_MISALIGN_TRAP_EN; the DUT runs with DM_TIMEOUT=4.
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid, ex_dmwe, ex_rwe, ex_rdst, ex_rwd;
  logic [31:0] ex_o, ex_b, ex_insn;
  logic        stall, dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        wb_valid, wb_rwe, wb_rdst, wb_rwd, dm_err, misalign;
  logic [31:0] wb_o, wb_d, wb_insn;

  int passed = 0;
  int total  = 0;

  int          obs_stall, obs_req;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_we;

  mem_stage #(.DM_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_o(ex_o), .ex_b(ex_b),
    .ex_insn(ex_insn), .ex_dmwe(ex_dmwe), .ex_rwe(ex_rwe), .ex_rdst(ex_rdst),
    .ex_rwd(ex_rwd), .stall(stall), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .wb_valid(wb_valid), .wb_o(wb_o), .wb_d(wb_d),
    .wb_insn(wb_insn), .wb_rwe(wb_rwe), .wb_rdst(wb_rdst), .wb_rwd(wb_rwd),
    .dm_err(dm_err), .misalign(misalign)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: access size in bytes, load result and store lanes from plain arithmetic.
  function automatic int msize(input logic [5:0] op);
    case (op)
      6'h20, 6'h24, 6'h28: return 1;
      6'h21, 6'h25, 6'h29: return 2;
      default:             return 4;
    endcase
  endfunction

  function automatic logic [31:0] mload(input logic [5:0] op, input int off, input logic [31:0] rd);
    logic [31:0] v;
    if (msize(op) == 1) begin
      v = (rd >> (8 * (3 - off))) & 32'hFF;
      if (op == 6'h20 && v[7]) v = v | 32'hFFFF_FF00;
    end else if (msize(op) == 2) begin
      v = (rd >> (16 * (1 - off / 2))) & 32'hFFFF;
      if (op == 6'h21 && v[15]) v = v | 32'hFFFF_0000;
    end else v = rd;
    return v;
  endfunction

  function automatic logic [31:0] mwdata(input logic [5:0] op, input logic [31:0] b);
    if (msize(op) == 1) return {24'h0, b[7:0]} * 32'h0101_0101;
    if (msize(op) == 2) return {16'h0, b[15:0]} * 32'h0001_0001;
    return b;
  endfunction

  function automatic logic [3:0] mbe(input logic [5:0] op, input int off);
    if (msize(op) == 1) return 4'(1 << (3 - off));
    if (msize(op) == 2) return 4'(3 << (2 * (1 - off / 2)));
    return 4'hF;
  endfunction

  function automatic logic mtrap(input logic [5:0] op, input int off);
`ifdef MEM_MISALIGN_TRAP_EN
    return (msize(op) == 2 && (off % 2) != 0) || (msize(op) == 4 && off != 0);
`else
    return 1'b0;
`endif
  endfunction

  // Presents one instruction at posedge+1, acks after `delay` request cycles, returns after it retires.
  task automatic apply_stimulus(input logic [5:0] op, input logic [31:0] o, input logic [31:0] b,
                                input logic dmwe, input logic rwd, input logic rwe, input logic rdst,
                                input logic [31:0] rdata, input int delay);
    int waits = 0;
    bit done = 0;
    bit seen = 0;
    obs_stall = 0;
    obs_req   = 0;
    ex_valid = 1'b1; ex_o = o; ex_b = b; ex_insn = {op, 26'($urandom)};
    ex_dmwe = dmwe; ex_rwd = rwd; ex_rwe = rwe; ex_rdst = rdst;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      dm_ack = 1'b0;
      if (dm_req) begin
        if (!seen) begin
          obs_addr = dm_addr; obs_we = dm_we; obs_wdata = dm_wdata; obs_be = dm_be; seen = 1;
        end
        obs_req++;
        if (waits == delay) begin dm_ack = 1'b1; dm_rdata = rdata; end
        waits++;
      end
      #4;
      if (stall) obs_stall++;
      else done = 1;
      @(posedge clock); #1;
    end
    if (!done) begin
      total++;
      $display("[TB] FAIL stall_bound: stall still high after 20 cycles, expected release");
    end
    ex_valid = 1'b0;
    dm_ack   = 1'b0;
  endtask

  task automatic check_output(input logic is_mem, input logic is_store, input logic trapped,
                              input logic [31:0] o, input logic rwe, input logic rwd, input int delay,
                              input int exp_stall, input logic [31:0] exp_d, input logic [31:0] exp_addr,
                              input logic [31:0] exp_wdata, input logic [3:0] exp_be);
    check("stall_cycles", obs_stall, exp_stall);
    check("wb_valid", wb_valid, 1);
    check("wb_o", wb_o, o);
    check("wb_insn", wb_insn, ex_insn);
    check("wb_rwe", wb_rwe, trapped ? 1'b0 : rwe);
    check("wb_rwd", wb_rwd, rwd);
    check("misalign", misalign, trapped);
    check("dm_req_after", dm_req, 0);
    if (!is_store) check("wb_d", wb_d, exp_d);
    if (is_mem && !trapped) begin
      check("req_cycles", obs_req, delay + 1);
      check("dm_addr", obs_addr, exp_addr);
      check("dm_we", obs_we, is_store);
      check("dm_be", obs_be, exp_be);
      if (is_store) check("dm_wdata", obs_wdata, exp_wdata);
    end else check("req_cycles", obs_req, 0);
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] o, b;
    logic        dmwe, rwd, rwe, rdst;
    logic [31:0] rdata;
    int          delay, exp_stall;
    logic [31:0] exp_d, exp_addr, exp_wdata;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t vecs[10];
  logic [5:0] ops[10] = '{6'h00, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h2F};

  initial begin
    vecs[0] = '{6'h00, 32'h5,         32'h0,         0, 0, 1, 1, 32'h0,         0, 0, 32'h0,         32'h0,    32'h0,         4'h0};
    vecs[1] = '{6'h20, 32'h1001,      32'h0,         0, 1, 1, 0, 32'h12F4_5678, 3, 4, 32'hFFFF_FFF4, 32'h1000, 32'h0,         4'h0};
    vecs[2] = '{6'h24, 32'h1001,      32'h0,         0, 1, 1, 0, 32'h12F4_5678, 3, 4, 32'h0000_00F4, 32'h1000, 32'h0,         4'h0};
    vecs[3] = '{6'h29, 32'h2002,      32'h0000_ABCD, 1, 0, 0, 0, 32'h0,         1, 2, 32'h0,         32'h2000, 32'hABCD_ABCD, 4'b0011};
    vecs[4] = '{6'h21, 32'h1002,      32'h0,         0, 1, 1, 0, 32'h1234_8765, 0, 1, 32'hFFFF_8765, 32'h1000, 32'h0,         4'h0};
    vecs[5] = '{6'h25, 32'h1000,      32'h0,         0, 1, 1, 0, 32'h8765_1234, 2, 3, 32'h0000_8765, 32'h1000, 32'h0,         4'h0};
    vecs[6] = '{6'h28, 32'h1003,      32'h0000_00AB, 1, 0, 0, 0, 32'h0,         2, 3, 32'h0,         32'h1000, 32'hABAB_ABAB, 4'b0001};
    vecs[7] = '{6'h23, 32'h3000,      32'h0,         0, 1, 1, 0, 32'hDEAD_BEEF, 1, 2, 32'hDEAD_BEEF, 32'h3000, 32'h0,         4'h0};
    vecs[8] = '{6'h2B, 32'h4004,      32'hCAFE_F00D, 1, 0, 0, 0, 32'h0,         0, 1, 32'h0,         32'h4004, 32'hCAFE_F00D, 4'b1111};
    vecs[9] = '{6'h20, 32'h1002,      32'h0,         0, 1, 1, 0, 32'h12F4_5678, 1, 2, 32'h0000_0056, 32'h1000, 32'h0,         4'h0};

    reset = 1'b1; ex_valid = 1'b0; ex_o = 32'h0; ex_b = 32'h0; ex_insn = 32'h0;
    ex_dmwe = 1'b0; ex_rwe = 1'b0; ex_rdst = 1'b0; ex_rwd = 1'b0; dm_ack = 1'b0; dm_rdata = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_wb_valid", wb_valid, 0);
    check("reset_dm_req", dm_req, 0);
    check("reset_dm_be", dm_be, 0);
    check("reset_dm_err", dm_err, 0);
    check("reset_misalign", misalign, 0);
    check("reset_wb_o", wb_o, 0);
    check("reset_stall", stall, 0);
    reset = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].op, vecs[i].o, vecs[i].b, vecs[i].dmwe, vecs[i].rwd, vecs[i].rwe,
                     vecs[i].rdst, vecs[i].rdata, vecs[i].delay);
      check_output(vecs[i].dmwe | vecs[i].rwd, vecs[i].dmwe, 1'b0, vecs[i].o, vecs[i].rwe, vecs[i].rwd,
                   vecs[i].delay, vecs[i].exp_stall, vecs[i].exp_d, vecs[i].exp_addr,
                   vecs[i].exp_wdata, vecs[i].exp_be);
    end

    $display("[TB] back-to-back LW then ADD");
    ex_valid = 1'b1; ex_o = 32'h6000; ex_b = 32'h0; ex_insn = {6'h23, 26'h0AB_CDEF};
    ex_dmwe = 1'b0; ex_rwd = 1'b1; ex_rwe = 1'b1; ex_rdst = 1'b0;
    #4 check("b2b_accept_stall", stall, 1);
    @(posedge clock); #1;
    check("b2b_req", dm_req, 1);
    dm_ack = 1'b1; dm_rdata = 32'h1122_3344;
    #4 check("b2b_ack_stall", stall, 0);
    @(posedge clock); #1;
    dm_ack = 1'b0;
    check("b2b_lw_valid", wb_valid, 1);
    check("b2b_lw_insn", wb_insn, {6'h23, 26'h0AB_CDEF});
    check("b2b_lw_d", wb_d, 32'h1122_3344);
    check("b2b_req_drop", dm_req, 0);
    ex_o = 32'h7; ex_insn = 32'h0000_0020; ex_rwd = 1'b0; ex_rdst = 1'b1;
    #4 check("b2b_add_stall", stall, 0);
    @(posedge clock); #1;
    check("b2b_add_valid", wb_valid, 1);
    check("b2b_add_insn", wb_insn, 32'h0000_0020);
    check("b2b_add_o", wb_o, 32'h7);
    check("b2b_no_reissue", dm_req, 0);
    ex_valid = 1'b0;
    @(posedge clock); #1;
    check("b2b_bubble", wb_valid, 0);
    check("b2b_still_no_req", dm_req, 0);

    $display("[TB] random ops");
    for (int n = 0; n < 60; n++) begin
      logic [5:0]  op;
      logic [31:0] o, b, rd;
      logic        st, ld, tr;
      int          dl, off;
      op  = ops[$urandom_range(0, 9)];
      o   = $urandom; b = $urandom; rd = $urandom;
      dl  = $urandom_range(0, 3);
      off = int'(o[1:0]);
      st  = (op == 6'h28 || op == 6'h29 || op == 6'h2B);
      ld  = (op != 6'h00) && !st;
      tr  = (st || ld) && mtrap(op, off);
      apply_stimulus(op, o, b, st, ld, !st, op == 6'h00, rd, dl);
      check_output(st || ld, st, tr, o, !st, ld, dl, ((st || ld) && !tr) ? dl + 1 : 0,
                   (ld && !tr) ? mload(op, off, rd) : 32'h0, {o[31:2], 2'b00},
                   mwdata(op, b), st ? mbe(op, off) : 4'h0);
    end

    $display("[TB] LW at 0x3001");
`ifdef MEM_MISALIGN_TRAP_EN
    ex_valid = 1'b1; ex_o = 32'h3001; ex_b = 32'h0; ex_insn = {6'h23, 26'h0};
    ex_dmwe = 1'b0; ex_rwd = 1'b1; ex_rwe = 1'b1; ex_rdst = 1'b0;
    #4 check("trap_stall", stall, 0);
    @(posedge clock); #1;
    check("trap_pulse", misalign, 1);
    check("trap_wb_valid", wb_valid, 1);
    check("trap_wb_rwe", wb_rwe, 0);
    check("trap_no_req", dm_req, 0);
    ex_valid = 1'b0;
    @(posedge clock); #1;
    check("trap_pulse_end", misalign, 0);
    check("trap_still_no_req", dm_req, 0);
`else
    apply_stimulus(6'h23, 32'h3001, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0BAD_F00D, 0);
    check_output(1'b1, 1'b0, 1'b0, 32'h3001, 1'b1, 1'b1, 0, 1, 32'h0BAD_F00D, 32'h3000, 32'h0, 4'h0);
`endif

    $display("[TB] timeout");
    apply_stimulus(6'h23, 32'h5000, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 99);
    check("to_stall_cycles", obs_stall, 4);
    check("to_req_cycles", obs_req, 4);
    check("to_dm_req", dm_req, 0);
    check("to_dm_err", dm_err, 1);
    check("to_wb_valid", wb_valid, 1);
    check("to_wb_rwe", wb_rwe, 0);
    apply_stimulus(6'h00, 32'h9, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 0);
    check("to_err_sticky", dm_err, 1);
    check("to_next_wb_o", wb_o, 32'h9);

    $display("[TB] reset mid-WAIT");
    ex_valid = 1'b1; ex_o = 32'h8000; ex_insn = {6'h23, 26'h0}; ex_dmwe = 1'b0; ex_rwd = 1'b1; ex_rwe = 1'b1;
    @(posedge clock); #1;
    check("rst_req_up", dm_req, 1);
    @(posedge clock); #1;
    reset = 1'b1; ex_valid = 1'b0;
    @(posedge clock); #1;
    check("rst_req_drop", dm_req, 0);
    check("rst_err_clear", dm_err, 0);
    check("rst_stall", stall, 0);
    reset = 1'b0;
    dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    dm_ack = 1'b0;
    check("rst_late_ack_valid", wb_valid, 0);
    check("rst_late_ack_req", dm_req, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
